// File: rtl/shift_line.sv
`default_nettype none
// ============================================================================
// Module      : shift_line
// Description : Parametrised, stallable delay line with a per-stage valid tag,
//               a runtime-selectable output tap and a fixed last-stage tap.
//               Used to match address/twiddle paths to butterfly latency.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DATA_W  data bits per stage
//   DEPTH   number of register stages (>=2)
//   SEL_W   width of the tap select
// Ports:
//   clk        in   rising-edge clock
//   rstn       in   asynchronous active-low reset
//   en         in   shift enable, 0 holds every stage (stall)
//   clr        in   synchronous clear of all stages and valid tags
//   din        in   data into stage 0
//   vin        in   valid tag travelling with din
//   tap_sel    in   tap select; tap k = k+1 enabled cycles of delay
//   dout       out  data at the selected tap (combinational mux)
//   vout       out  valid tag at the selected tap
//   dout_last  out  data at stage DEPTH-1
//   vout_last  out  valid tag at stage DEPTH-1
//   primed     out  (SHIFT_LINE_PRIMED_EN only) high once DEPTH enabled
//                   shifts have occurred since reset/clear
// Build option:
//   SHIFT_LINE_PRIMED_EN  adds the primed output and its fill counter
// ============================================================================
module shift_line #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 9,
  parameter int SEL_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  input  logic              vin,
  input  logic [SEL_W-1:0]  tap_sel,
  output logic [DATA_W-1:0] dout,
  output logic              vout,
  output logic [DATA_W-1:0] dout_last,
  output logic              vout_last
`ifdef SHIFT_LINE_PRIMED_EN
  ,
  output logic              primed
`endif
);

  localparam logic [SEL_W:0] LAST_IDX = (SEL_W+1)'(DEPTH-1);

  logic [DATA_W-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0]  stage_vld;

  logic [SEL_W:0]    sel_ext;
  logic [SEL_W:0]    sel_clamped;
  logic [SEL_W-1:0]  sel_idx;

  // Shift register: clear dominates enable, valid tag shifts blindly with data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_data[i] <= '0;
      end
      stage_vld <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_data[i] <= '0;
      end
      stage_vld <= '0;
    end else if (en) begin
      stage_data[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_data[i] <= stage_data[i-1];
      end
      stage_vld <= {stage_vld[DEPTH-2:0], vin};
    end
  end

  // Select is widened by one bit so the clamp compare cannot wrap; after the
  // clamp the value always fits back into SEL_W bits.
  always_comb begin
    sel_ext     = {1'b0, tap_sel};
    sel_clamped = (sel_ext > LAST_IDX) ? LAST_IDX : sel_ext;
    sel_idx     = sel_clamped[SEL_W-1:0];
  end

  assign dout      = stage_data[sel_idx];
  assign vout      = stage_vld[sel_idx];
  assign dout_last = stage_data[DEPTH-1];
  assign vout_last = stage_vld[DEPTH-1];

`ifdef SHIFT_LINE_PRIMED_EN
  localparam int             CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(DEPTH);

  logic [CNT_W-1:0] fill_cnt;
  logic [CNT_W-1:0] fill_next;

  always_comb begin
    fill_next = fill_cnt;
    if (en && (fill_cnt != FILL_MAX)) begin
      fill_next = fill_cnt + CNT_W'(1);
    end
  end

  // primed is registered from the next count so it rises on the very edge
  // that performs the DEPTH-th enabled shift.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_cnt <= '0;
      primed   <= 1'b0;
    end else if (clr) begin
      fill_cnt <= '0;
      primed   <= 1'b0;
    end else begin
      fill_cnt <= fill_next;
      primed   <= (fill_next == FILL_MAX);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_line.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_line
// Description : Directed self-checking bench for shift_line (DATA_W=14,
//               DEPTH=9). Primed checks are active when SHIFT_LINE_PRIMED_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_line;

  localparam int DATA_W = 14;
  localparam int DEPTH  = 9;
  localparam int SEL_W  = 4;

  logic              clk;
  logic              rstn;
  logic              en;
  logic              clr;
  logic [DATA_W-1:0] din;
  logic              vin;
  logic [SEL_W-1:0]  tap_sel;
  logic [DATA_W-1:0] dout;
  logic              vout;
  logic [DATA_W-1:0] dout_last;
  logic              vout_last;
`ifdef SHIFT_LINE_PRIMED_EN
  logic              primed;
`endif

  int checks;
  int failures;

  shift_line #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SEL_W  (SEL_W)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .clr       (clr),
    .din       (din),
    .vin       (vin),
    .tap_sel   (tap_sel),
    .dout      (dout),
    .vout      (vout),
    .dout_last (dout_last),
    .vout_last (vout_last)
`ifdef SHIFT_LINE_PRIMED_EN
    ,
    .primed    (primed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_d;
    checks   = 0;
    failures = 0;
    rstn     = 1'b1;
    en       = 1'b0;
    clr      = 1'b0;
    din      = '0;
    vin      = 1'b0;
    tap_sel  = '0;

    // ---------------- reset ----------------
    #1 rstn = 1'b0;
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_vout", 32'(vout), 32'h0);
    chk("rst_dout_last", 32'(dout_last), 32'h0);
`ifdef SHIFT_LINE_PRIMED_EN
    chk("rst_primed", 32'(primed), 32'h0);
`endif
    tick();
    tick();
    #2 rstn = 1'b1;
    #1;
    chk("post_rel_dout_last", 32'(dout_last), 32'h0);
    chk("post_rel_vout_last", 32'(vout_last), 32'h0);

    // ---------------- 1: single word through tap 8 ----------------
    en      = 1'b1;
    tap_sel = 4'd8;
    din     = 14'h1A3F;
    vin     = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      din = '0;
      vin = 1'b0;
      exp_d = (c == 9) ? 14'h1A3F : 14'h0;
      chk($sformatf("t1_dout_c%0d", c), 32'(dout), 32'(exp_d));
      chk($sformatf("t1_vout_c%0d", c), 32'(vout), (c == 9) ? 32'h1 : 32'h0);
      chk($sformatf("t1_dlast_c%0d", c), 32'(dout_last), 32'(exp_d));
      chk($sformatf("t1_vlast_c%0d", c), 32'(vout_last), (c == 9) ? 32'h1 : 32'h0);
    end

    // ---------------- 2: ramp, tap 2 then tap 0 ----------------
    tap_sel = 4'd2;
    vin     = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      din = 14'(n);
      #1;
      if (n >= 4) begin
        chk($sformatf("t2_tap2_din%0d", n), 32'(dout), 32'(n - 3));
        chk($sformatf("t2_vout_din%0d", n), 32'(vout), 32'h1);
      end
      tick();
    end
    din     = 14'd9;
    tap_sel = 4'd0;
    #1;
    chk("t2_tap0_din9", 32'(dout), 32'd8);
    tick();

    // ---------------- 4: clear with enable (pipeline full of valid data) ----
    chk("t4_full_vlast", 32'(vout_last), 32'h1);
    chk("t4_full_dlast", 32'(dout_last), 32'd1);
    clr = 1'b1;
    en  = 1'b1;
    din = 14'h3FFF;
    vin = 1'b1;
    tick();
    clr = 1'b0;
    en  = 1'b0;
    vin = 1'b0;
    din = '0;
    #1;
    chk("t4_dout_tap0", 32'(dout), 32'h0);
    chk("t4_vout_tap0", 32'(vout), 32'h0);
    chk("t4_dout_last", 32'(dout_last), 32'h0);
    chk("t4_vout_last", 32'(vout_last), 32'h0);
    tap_sel = 4'd4;
    #1;
    chk("t4_dout_tap4", 32'(dout), 32'h0);
    tick();
    tap_sel = 4'd0;
    #1;
    chk("t4_discarded", 32'(dout), 32'h0);

    // ---------------- 3: stall for 4 cycles ----------------
    tap_sel = 4'd1;
    for (int e = 1; e <= 16; e++) begin
      case (e)
        1:       begin en = 1'b1; din = 14'd10; vin = 1'b1; end
        2:       begin en = 1'b1; din = 14'd11; vin = 1'b1; end
        3,4,5,6: begin en = 1'b0; din = 14'd99; vin = 1'b1; end
        7:       begin en = 1'b1; din = 14'd12; vin = 1'b1; end
        default: begin en = 1'b1; din = 14'd0;  vin = 1'b0; end
      endcase
      tick();
      case (e)
        13:      exp_d = 14'd10;
        14:      exp_d = 14'd11;
        15:      exp_d = 14'd12;
        default: exp_d = 14'd0;
      endcase
      chk($sformatf("t3_dlast_e%0d", e), 32'(dout_last), 32'(exp_d));
      if (e >= 2 && e <= 6) begin
        chk($sformatf("t3_frozen_tap1_e%0d", e), 32'(dout), 32'd10);
      end
      if (e == 7) begin
        chk("t3_resume_tap1", 32'(dout), 32'd11);
      end
    end

    // ---------------- 5: out-of-range select clamps to last ----------------
    tap_sel = 4'd15;
    en      = 1'b1;
    vin     = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      din = 14'(32'h100 + n);
      tick();
      exp_d = (n >= 9) ? 14'(32'h100 + n - 8) : 14'h0;
      chk($sformatf("t5_dout_n%0d", n), 32'(dout), 32'(exp_d));
      chk($sformatf("t5_eq_last_n%0d", n), 32'(dout), 32'(dout_last));
    end

    // ---------------- 6: fill/primed and reset mid-run ----------------
    en = 1'b0;
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    tap_sel = 4'd0;
    vin     = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      en  = (e == 3) ? 1'b0 : 1'b1;
      din = 14'(32'h2000 + e);
      tick();
`ifdef SHIFT_LINE_PRIMED_EN
      chk($sformatf("t6_primed_e%0d", e), 32'(primed), (e >= 10) ? 32'h1 : 32'h0);
`endif
    end
    chk("t6_pre_rst_tap0", 32'(dout), 32'h200B);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rst_dout", 32'(dout), 32'h0);
    chk("t6_rst_vout", 32'(vout), 32'h0);
    chk("t6_rst_dout_last", 32'(dout_last), 32'h0);
`ifdef SHIFT_LINE_PRIMED_EN
    chk("t6_rst_primed", 32'(primed), 32'h0);
`endif
    #3 rstn = 1'b1;
    en = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
